serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the board's single UART transmitter between several byte-stream sources: the command-response path, the histogram dump and the status/monitor readout. Each source posts a packet length and exposes a synchronous byte buffer. The arbiter grants one source at a time in round-robin order, fetches that source's bytes and drives the transmitter's start/busy handshake. It sits between the command processor / histogram logic and the UART TX core.

## Interface

Parameters:
- NREQ, 3, number of requesters (2..8)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  request per source; level, held until matching `done`
- len  in  8*NREQ  packet length in bytes per source (slice i = `len[8i+7:8i]`); sampled at grant
- rd_data  in  8*NREQ  byte from each source's buffer; valid one cycle after `rd_addr`
- rd_addr  out  8  shared byte index into the granted source's buffer
- grant  out  NREQ  one-hot grant; zero when idle
- done  out  NREQ  one-cycle pulse when the granted packet has fully been handed to the UART
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle start strobe to the UART
- tx_data  out  8  byte to the UART; stable while `tx_start` is high
- busy  out  1  high in any state other than IDLE

## Operation

- States: IDLE, FETCH, LOAD, WAITTX, START, ACK.
- **IDLE**
  - If `req` is nonzero, choose the first set bit searching upward from `last+1`, wrapping modulo NREQ.
  - Register `grant`, set `last` to the winner, latch `cnt_len = len[winner]` and set `rd_addr = 0`.
  - If `cnt_len == 0`: pulse `done[winner]`, clear `grant`, stay in IDLE.
  - Otherwise go to FETCH.
- **FETCH:** `rd_addr` is presented; go to LOAD.
- **LOAD:** capture the granted slice of `rd_data` into `tx_data`; go to WAITTX.
- **WAITTX:** wait for `tx_busy == 0`, then go to START.
- **START:** `tx_start = 1` for exactly one cycle; go to ACK.
- **ACK:** wait for `tx_busy == 1`, or for 4 cycles in ACK, whichever comes first. The timeout prevents a hang on a missed busy edge.
  - If `rd_addr == cnt_len-1`: pulse `done[grant]`, clear `grant`, return to IDLE.
  - Otherwise: `rd_addr = rd_addr+1`, go to FETCH.
- Packet boundaries:
  - Dropping `req` mid-packet does not abort; the packet completes and `done` still pulses.
  - Changing `len` after grant has no effect.
  - Other requests arriving during a packet wait; arbitration happens only in IDLE.
  - A source whose `req` is still high in the cycle after its `done` is treated as a new request.
- Widths:
  - `rd_addr` and the byte counter are 8 bits; maximum payload is 255 bytes.
  - No wrap past `cnt_len-1`.
- Reset (asynchronous, any state): state = IDLE; `grant = 0`, `done = 0`, `tx_start = 0`, `tx_data = 0`, `rd_addr = 0`, `busy = 0`.
  - `last = NREQ-1`, so source 0 wins the first arbitration.
  - An in-flight packet is dropped without a `done`.

## Timing

- Latency from `req` rising in IDLE (UART idle) to `tx_start`: 4 cycles (IDLE→FETCH→LOAD→WAITTX→START).
- Per byte: `tx_start` pulses are separated by at least the UART busy period plus 4 cycles (ACK exit→FETCH→LOAD→WAITTX→START).
- `done` rises the cycle after ACK exits for the last byte. It coincides with IDLE, and `grant` is already 0 in that cycle.
- `busy` and `grant` are registered; there is no combinational path from inputs to outputs.

## Configuration

- TXARB_HEADER_EN
  - **Defined:** every packet is prefixed by two header bytes, `8'hA0 | winner` then `cnt_len`, sent through the same FETCH-less WAITTX/START/ACK sequence. `rd_addr` stays 0 during the header. `len == 0` then sends the header only and pulses `done` after the second header byte.
  - **Undefined:** raw payload only, byte-compatible with existing host software. A zero-length request is completed in IDLE with no UART activity.

## Test plan

- Single source: `req[0]=1`, `len[0]=3`, buffer {0x11,0x22,0x33}, UART busy 10 cycles per byte -> exactly 3 `tx_start` pulses carrying 0x11, 0x22, 0x33 in order; one `done[0]` pulse after the third; `grant` returns to 0.
- Round-robin: `req = 3'b111` held continuously, all lengths 1 -> grant order 0,1,2,0,1,2; no source is granted twice while another is waiting.
- Zero length: `len[1]=0`, `req[1]` pulse -> `done[1]` one cycle later, no `tx_start` (header macro off); with TXARB_HEADER_EN -> 2 `tx_start` pulses carrying 0xA1, 0x00, then `done[1]`.
- Lost busy: `tx_busy` tied low, `len=2` -> ACK times out after 4 cycles; 2 `tx_start` pulses; `done` still issued.
- Reset mid-packet: assert `rstn=0` during byte 2 of 5 -> all outputs 0 immediately; after release, a `req[2]` alone is granted and sends from `rd_addr=0`.
- Request drop: deassert `req[0]` after its first byte of 4 -> all 4 bytes sent and `done[0]` pulses.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte-stream sources.
// Define TXARB_HEADER_EN to prefix each packet with the header bytes {8'hA0 | source, length}.
module serial_tx_arbiter #(
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] len,
  input  logic [8*NREQ-1:0] rd_data,
  output logic [7:0]        rd_addr,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAITTX, START, ACK} state_t;

  state_t          state_reg;
  logic [IDX_W-1:0] last_reg;
  logic [7:0]      cnt_len_reg;
  logic [7:0]      rd_addr_reg;
  logic [7:0]      tx_data_reg;
  logic [NREQ-1:0] grant_reg;
  logic [NREQ-1:0] done_reg;
  logic            tx_start_reg;
  logic            busy_reg;
  logic [1:0]      ack_cnt_reg;
`ifdef TXARB_HEADER_EN
  logic [1:0]      hdr_reg;
`endif

  logic [7:0] len_arr [NREQ];
  logic [7:0] rd_arr  [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign len_arr[gi] = len[8*gi +: 8];
      assign rd_arr[gi]  = rd_data[8*gi +: 8];
    end
  endgenerate

  // Search upward from the source after the last winner, wrapping around.
  logic             req_any;
  logic [IDX_W-1:0] winner;
  logic [NREQ-1:0]  winner_onehot;
  int               idx;

  always_comb begin
    req_any = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_reg) + k) % NREQ;
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

  assign winner_onehot = NREQ'(1) << winner;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      last_reg     <= IDX_W'(NREQ - 1);
      cnt_len_reg  <= '0;
      rd_addr_reg  <= '0;
      tx_data_reg  <= '0;
      grant_reg    <= '0;
      done_reg     <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ack_cnt_reg  <= '0;
`ifdef TXARB_HEADER_EN
      hdr_reg      <= '0;
`endif
    end else begin
      done_reg     <= '0;
      tx_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            last_reg    <= winner;
            cnt_len_reg <= len_arr[winner];
            rd_addr_reg <= '0;
`ifdef TXARB_HEADER_EN
            grant_reg   <= winner_onehot;
            tx_data_reg <= 8'hA0 | 8'(winner);
            hdr_reg     <= 2'd2;
            busy_reg    <= 1'b1;
            state_reg   <= WAITTX;
`else
            if (len_arr[winner] == 8'd0) begin
              done_reg <= winner_onehot;
            end else begin
              grant_reg <= winner_onehot;
              busy_reg  <= 1'b1;
              state_reg <= FETCH;
            end
`endif
          end
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          tx_data_reg <= rd_arr[last_reg];
          state_reg   <= WAITTX;
        end
        WAITTX: begin
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            state_reg    <= START;
          end
        end
        START: begin
          ack_cnt_reg <= '0;
          state_reg   <= ACK;
        end
        ACK: begin
          // Leave on the UART's busy edge, or after four cycles if that edge was missed.
          if (tx_busy || ack_cnt_reg == 2'd3) begin
`ifdef TXARB_HEADER_EN
            if (hdr_reg == 2'd2) begin
              tx_data_reg <= cnt_len_reg;
              hdr_reg     <= 2'd1;
              state_reg   <= WAITTX;
            end else if (hdr_reg == 2'd1) begin
              hdr_reg <= 2'd0;
              if (cnt_len_reg == 8'd0) begin
                done_reg  <= grant_reg;
                grant_reg <= '0;
                busy_reg  <= 1'b0;
                state_reg <= IDLE;
              end else begin
                state_reg <= FETCH;
              end
            end else
`endif
            if (rd_addr_reg == cnt_len_reg - 8'd1) begin
              done_reg  <= grant_reg;
              grant_reg <= '0;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              rd_addr_reg <= rd_addr_reg + 8'd1;
              state_reg   <= FETCH;
            end
          end else begin
            ack_cnt_reg <= ack_cnt_reg + 2'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_reg;
  assign grant    = grant_reg;
  assign done     = done_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: a vector table of whole-packet scenarios plus
// hand-written sequences for latency, round-robin, zero length, lost busy, reset and request drop.
module tb_serial_tx_arbiter;
  localparam int NREQ = 3;
`ifdef TXARB_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] len;
  logic [8*NREQ-1:0] rd_data;
  logic [7:0]        rd_addr;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              busy;

  serial_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rstn(rstn), .req(req), .len(len), .rd_data(rd_data),
    .rd_addr(rd_addr), .grant(grant), .done(done), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 10;
  int busy_cnt = 0;
  logic [NREQ-1:0] auto_drop;
  logic [7:0] tx_bytes[$];
  int tx_cyc[$];
  int done_src[$];

  // Buffer contents of source s at address a.
  function automatic logic [7:0] src_byte(input int s, input int a);
    return 8'((s << 6) + 'h11 * (a + 1));
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] g);
    for (int s = 0; s < NREQ; s++) if (g[s]) return s;
    return -1;
  endfunction

  // Synchronous source buffers: data follows rd_addr by one cycle.
  always @(posedge clk) begin
    for (int s = 0; s < NREQ; s++) rd_data[8*s +: 8] <= src_byte(s, int'(rd_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, log traffic, then update the UART busy model.
  task automatic step();
    @(negedge clk);
    cyc++;
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (tx_start) begin
      tx_bytes.push_back(tx_data);
      tx_cyc.push_back(cyc);
      $display("tx: cycle %0d src %0d byte 0x%02h", cyc, oh_idx(grant), tx_data);
    end
    if (done != '0) begin
      check("done_grant_clear", 32'(grant), 32'd0);
      check("done_busy_clear", 32'(busy), 32'd0);
    end
    for (int s = 0; s < NREQ; s++) begin
      if (done[s]) begin
        done_src.push_back(s);
        if (auto_drop[s]) req[s] = 1'b0;
      end
    end
    if (busy_cnt > 0) busy_cnt--;
    if (tx_start) busy_cnt = busy_len;
    tx_busy = (busy_cnt > 0);
  endtask

  task automatic clear_logs();
    tx_bytes.delete();
    tx_cyc.delete();
    done_src.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0;
    len = '0;
    busy_len = 10;
    busy_cnt = 0;
    tx_busy = 1'b0;
    auto_drop = '1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (done_src.size() < n && k < limit) begin
      step();
      k++;
    end
    check({name, " done_count"}, done_src.size(), n);
  endtask

  // Expected stream: requesting sources in ascending order, header (if built) then payload.
  task automatic check_stream(input string name, input logic [NREQ-1:0] srcs,
                              input logic [8*NREQ-1:0] lens);
    logic [7:0] exp_q[$];
    int exp_d[$];
    for (int s = 0; s < NREQ; s++) begin
      if (srcs[s]) begin
        int n;
        n = int'(lens[8*s +: 8]);
        if (HDR > 0) begin
          exp_q.push_back(8'hA0 | 8'(s));
          exp_q.push_back(lens[8*s +: 8]);
        end
        for (int a = 0; a < n; a++) exp_q.push_back(src_byte(s, a));
        exp_d.push_back(s);
      end
    end
    check({name, " ntx"}, tx_bytes.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tx_bytes.size(); k++)
      check($sformatf("%s byte%0d", name, k), 32'(tx_bytes[k]), 32'(exp_q[k]));
    for (int k = 0; k < exp_d.size() && k < done_src.size(); k++)
      check($sformatf("%s done%0d", name, k), done_src[k], exp_d[k]);
  endtask

  typedef struct {
    string           name;
    logic [NREQ-1:0] req;
    logic [8*NREQ-1:0] len;
    int              busy_len;
    int              exp_ntx;    // payload bytes only
    int              exp_ndone;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n;
    rstn = 1'b0;
    req = '0;
    len = '0;
    tx_busy = 1'b0;
    auto_drop = '1;

    vecs[0] = '{"single3",    3'b001, 24'h000003, 10, 3, 1};
    vecs[1] = '{"two_src",    3'b011, 24'h000201,  3, 3, 2};
    vecs[2] = '{"all_three",  3'b111, 24'h020103,  1, 6, 3};
    vecs[3] = '{"lost_busy",  3'b001, 24'h000002,  0, 2, 1};
    vecs[4] = '{"zero_mixed", 3'b101, 24'h000002,  4, 2, 2};
    vecs[5] = '{"zero_only",  3'b010, 24'h000000,  2, 0, 1};
    vecs[6] = '{"five_src2",  3'b100, 24'h050000,  2, 5, 1};

    // Reset state, with requests already pending.
    req = 3'b111;
    len = 24'h010101;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      len = vecs[v].len;
      busy_len = vecs[v].busy_len;
      req = vecs[v].req;
      wait_done(vecs[v].exp_ndone, 800, vecs[v].name);
      repeat (12) step();
      check({vecs[v].name, " count"}, tx_bytes.size(),
            vecs[v].exp_ntx + HDR * $countones(vecs[v].req));
      check({vecs[v].name, " idle_grant"}, 32'(grant), 32'd0);
      check_stream(vecs[v].name, vecs[v].req, vecs[v].len);
      $display("vector %s: %0d bytes, %0d done", vecs[v].name, tx_bytes.size(), done_src.size());
    end

    // Latency from request to first start strobe.
    do_reset();
    len = 24'h000003;
    req = 3'b001;
    step();
    n = 1;
    check("lat_grant", 32'(grant), 32'd1);
    while (tx_bytes.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check("lat_cycles", n, (HDR > 0) ? 2 : 4);
    wait_done(1, 300, "lat");
    check_stream("lat", 3'b001, 24'h000003);

    // Round-robin with all requests held continuously.
    do_reset();
    len = 24'h010101;
    busy_len = 2;
    auto_drop = '0;
    req = 3'b111;
    n = 0;
    while (done_src.size() < 6 && n < 600) begin
      step();
      n++;
    end
    req = '0;
    check("rr_count", done_src.size(), 6);
    for (int k = 0; k < 6 && k < done_src.size(); k++)
      check($sformatf("rr_order%0d", k), done_src[k], k % 3);
    repeat (10) step();
    check("rr_no_extra", done_src.size(), 6);

    // Zero-length single-cycle request.
    do_reset();
    len = 24'h000000;
    req = 3'b010;
    step();
    req = '0;
    if (HDR == 0) begin
      check("zero_done_next", 32'(done), 32'b010);
      repeat (10) step();
    end else begin
      wait_done(1, 100, "zero_hdr");
      repeat (4) step();
    end
    check_stream("zero", 3'b010, 24'h000000);

    // Missed busy edge: ACK times out, byte spacing is ACK(4)+FETCH+LOAD+WAITTX+START.
    do_reset();
    busy_len = 0;
    len = 24'h000002;
    req = 3'b001;
    wait_done(1, 200, "lostb");
    check("lostb_ntx", tx_bytes.size(), HDR + 2);
    if (tx_cyc.size() >= 2)
      check("lostb_gap", tx_cyc[tx_cyc.size()-1] - tx_cyc[tx_cyc.size()-2], 8);

    // Reset in the middle of byte 2 of 5.
    do_reset();
    busy_len = 3;
    len = 24'h000005;
    req = 3'b001;
    n = 0;
    while (tx_bytes.size() < HDR + 2 && n < 300) begin
      step();
      n++;
    end
    check("rstmid_reach", tx_bytes.size(), HDR + 2);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_grant", 32'(grant), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_tx_data", 32'(tx_data), 32'd0);
    check("rstmid_rd_addr", 32'(rd_addr), 32'd0);
    check("rstmid_tx_start", 32'(tx_start), 32'd0);
    req = '0;
    busy_cnt = 0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clear_logs();
    len = 24'h020005;
    auto_drop = '1;
    req = 3'b100;
    step();
    check("rstmid_regrant", 32'(grant), 32'b100);
    check("rstmid_addr0", 32'(rd_addr), 32'd0);
    wait_done(1, 300, "rstmid");
    check_stream("rstmid", 3'b100, 24'h020000);

    // Request dropped and length changed after the first byte.
    do_reset();
    busy_len = 3;
    auto_drop = '0;
    len = 24'h000004;
    req = 3'b001;
    n = 0;
    while (tx_bytes.size() < HDR + 1 && n < 300) begin
      step();
      n++;
    end
    req = '0;
    len = 24'h000001;
    wait_done(1, 400, "drop");
    repeat (10) step();
    check_stream("drop", 3'b001, 24'h000004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
